// File: rtl/dehaze_pkg.sv
// Shared widths, the sync bundle type and the pixel clamp used by the
// dehaze recovery stage.
//   PIX_W     pixel/channel width
//   RCP_W     reciprocal width (Q4.8, unsigned)
//   RCP_FRAC  fractional bits of the reciprocal
//   PROD_W    signed product width (9-bit diff x 13-bit signed rcp)
//   SUM_W     signed width of the pre-clamp result
//   T_MIN_DEF default lower bound applied to transmittance
package dehaze_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned RCP_W     = 12;
  localparam int unsigned RCP_FRAC  = 8;
  localparam int unsigned PROD_W    = 22;
  localparam int unsigned SUM_W     = 16;
  localparam int unsigned T_MIN_DEF = 26;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // Saturate a signed intermediate to the 0..255 pixel range.
  function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1])
      return '0;
    else if (|s[SUM_W-2:PIX_W])
      return '1;
    else
      return s[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/dehaze_recip_rom.sv
// Reciprocal lookup: rcp = round(65280 / t) in Q4.8, one-cycle registered read.
//   pixelclk  clock
//   reset_n   synchronous active-low reset (clears the read register)
//   addr      transmittance, already clamped to >= T_MIN by the caller
//   rcp       registered reciprocal
module dehaze_recip_rom
  import dehaze_pkg::*;
#(
  parameter int unsigned T_MIN = T_MIN_DEF
) (
  input  logic             pixelclk,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] addr,
  output logic [RCP_W-1:0] rcp
);

  localparam int unsigned NUM     = 255 * 256;
  localparam int unsigned RCP_MAX = (1 << RCP_W) - 1;

  // Entries below T_MIN are never addressed; saturate them to keep them in range.
  function automatic logic [RCP_W-1:0] recip(input int unsigned t);
    int unsigned v;
    if (t == 0 || t < T_MIN) return '1;
    v = (NUM + t / 2) / t;
    if (v > RCP_MAX) v = RCP_MAX;
    return RCP_W'(v);
  endfunction

  logic [RCP_W-1:0] rom [256];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    assign rom[g] = recip(g);
  end

  logic [RCP_W-1:0] rcp_d, rcp_q;

  always_comb begin
    rcp_d = rom[addr];
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) rcp_q <= '0;
    else          rcp_q <= rcp_d;
  end

  assign rcp = rcp_q;

endmodule

// File: rtl/dehaze_recover.sv
// Dehaze recovery: J = A + (I - A) * 255 / t per channel, clamped to 0..255,
// five-stage pipeline with hsync/vsync/de delayed to match.
//   pixelclk, reset_n          clock, synchronous active-low reset
//   i_r/i_g/i_b                hazy input pixel
//   i_transmittance            t for the same pixel (255 = 1.0)
//   i_atmos                    atmospheric light, latched on vsync rise
//   i_hsync/i_vsync/i_de       input timing
//   i_bypass                   only with DEHAZE_RECOVER_BYPASS_EN: pass RGB through
//   o_r/o_g/o_b                recovered pixel (0 while de is low)
//   o_hsync/o_vsync/o_de       timing delayed by LATENCY cycles
module dehaze_recover
  import dehaze_pkg::*;
#(
  parameter int unsigned      T_MIN   = T_MIN_DEF,
  parameter logic [PIX_W-1:0] A_RESET = 8'd255,
  parameter int unsigned      LATENCY = 5
) (
  input  logic             pixelclk,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] i_r,
  input  logic [PIX_W-1:0] i_g,
  input  logic [PIX_W-1:0] i_b,
  input  logic [PIX_W-1:0] i_transmittance,
  input  logic [PIX_W-1:0] i_atmos,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic             i_de,
`ifdef DEHAZE_RECOVER_BYPASS_EN
  input  logic             i_bypass,
`endif
  output logic [PIX_W-1:0] o_r,
  output logic [PIX_W-1:0] o_g,
  output logic [PIX_W-1:0] o_b,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de
);

  localparam logic signed [PROD_W-1:0] RND = PROD_W'(1) << (RCP_FRAC - 1);

  logic [PIX_W-1:0]         pix_in [3];
  logic [PIX_W-1:0]         a_frame_d, a_frame_q;
  sync_t                    sync_d [LATENCY];
  sync_t                    sync_q [LATENCY];
  logic [PIX_W-1:0]         t1_d, t1_q;
  logic [PIX_W-1:0]         a1_d, a1_q, a2_d, a2_q, a3_d, a3_q;
  logic signed [PIX_W:0]    d1_d [3];
  logic signed [PIX_W:0]    d1_q [3];
  logic signed [PIX_W:0]    d2_d [3];
  logic signed [PIX_W:0]    d2_q [3];
  logic signed [PROD_W-1:0] p3_d [3];
  logic signed [PROD_W-1:0] p3_q [3];
  logic signed [SUM_W-1:0]  s4_d [3];
  logic signed [SUM_W-1:0]  s4_q [3];
  logic [PIX_W-1:0]         o_d  [3];
  logic [PIX_W-1:0]         o_q  [3];
  logic [RCP_W-1:0]         rcp;
`ifdef DEHAZE_RECOVER_BYPASS_EN
  logic [2:0]               byp_d, byp_q;
  logic signed [PIX_W:0]    d3_d [3];
  logic signed [PIX_W:0]    d3_q [3];
`endif

  dehaze_recip_rom #(.T_MIN(T_MIN)) u_rom (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .addr     (t1_q),
    .rcp      (rcp)
  );

  always_comb begin
    pix_in[0] = i_r;
    pix_in[1] = i_g;
    pix_in[2] = i_b;

    sync_d[0] = {i_hsync, i_vsync, i_de};
    for (int unsigned k = 1; k < LATENCY; k++) sync_d[k] = sync_q[k-1];

    // sync_q[0].vs is the registered vsync; the latching pixel sees the new A.
    a_frame_d = (i_vsync && !sync_q[0].vs) ? i_atmos : a_frame_q;

    t1_d = (i_transmittance < PIX_W'(T_MIN)) ? PIX_W'(T_MIN) : i_transmittance;
    a1_d = a_frame_d;
    a2_d = a1_q;
    a3_d = a2_q;

    for (int unsigned c = 0; c < 3; c++) begin
      d1_d[c] = $signed({1'b0, pix_in[c]}) - $signed({1'b0, a_frame_d});
      d2_d[c] = d1_q[c];
      p3_d[c] = $signed({{(PROD_W-PIX_W-1){d2_q[c][PIX_W]}}, d2_q[c]})
              * $signed({{(PROD_W-RCP_W){1'b0}}, rcp});
      s4_d[c] = SUM_W'($signed({{(PROD_W-PIX_W){1'b0}}, a3_q})
              + ((p3_q[c] + RND) >>> RCP_FRAC));
`ifdef DEHAZE_RECOVER_BYPASS_EN
      d3_d[c] = d2_q[c];
      // A + (I - A) reconstructs the original channel without a separate RGB pipe.
      if (byp_q[2])
        s4_d[c] = $signed({{(SUM_W-PIX_W){1'b0}}, a3_q})
                + $signed({{(SUM_W-PIX_W-1){d3_q[c][PIX_W]}}, d3_q[c]});
`endif
      o_d[c] = sync_q[LATENCY-2].de ? clamp_pix(s4_q[c]) : '0;
    end

`ifdef DEHAZE_RECOVER_BYPASS_EN
    byp_d = {byp_q[1:0], i_bypass};
`endif
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      a_frame_q <= A_RESET;
      t1_q      <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      a3_q      <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) sync_q[k] <= '0;
      for (int unsigned c = 0; c < 3; c++) begin
        d1_q[c] <= '0;
        d2_q[c] <= '0;
        p3_q[c] <= '0;
        s4_q[c] <= '0;
        o_q[c]  <= '0;
`ifdef DEHAZE_RECOVER_BYPASS_EN
        d3_q[c] <= '0;
`endif
      end
`ifdef DEHAZE_RECOVER_BYPASS_EN
      byp_q <= '0;
`endif
    end else begin
      a_frame_q <= a_frame_d;
      t1_q      <= t1_d;
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      a3_q      <= a3_d;
      for (int unsigned k = 0; k < LATENCY; k++) sync_q[k] <= sync_d[k];
      for (int unsigned c = 0; c < 3; c++) begin
        d1_q[c] <= d1_d[c];
        d2_q[c] <= d2_d[c];
        p3_q[c] <= p3_d[c];
        s4_q[c] <= s4_d[c];
        o_q[c]  <= o_d[c];
`ifdef DEHAZE_RECOVER_BYPASS_EN
        d3_q[c] <= d3_d[c];
`endif
      end
`ifdef DEHAZE_RECOVER_BYPASS_EN
      byp_q <= byp_d;
`endif
    end
  end

  assign o_r     = o_q[0];
  assign o_g     = o_q[1];
  assign o_b     = o_q[2];
  assign o_hsync = sync_q[LATENCY-1].hs;
  assign o_vsync = sync_q[LATENCY-1].vs;
  assign o_de    = sync_q[LATENCY-1].de;

endmodule

// File: tb/tb_dehaze_recover.sv
// Directed bench for dehaze_recover; expected pixels are hand-computed from
// J = A + ((I - A) * round(65280 / max(t, 26)) + 128) >>> 8, clamped.
module tb_dehaze_recover;

  logic       pixelclk = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] i_r = '0, i_g = '0, i_b = '0, i_transmittance = '0, i_atmos = '0;
  logic       i_hsync = 1'b0, i_vsync = 1'b0, i_de = 1'b0;
`ifdef DEHAZE_RECOVER_BYPASS_EN
  logic       i_bypass = 1'b0;
`endif
  logic [7:0] o_r, o_g, o_b;
  logic       o_hsync, o_vsync, o_de;

  int n_checks = 0;
  int n_errors = 0;

  always #5 pixelclk = ~pixelclk;

  dehaze_recover dut (
    .pixelclk        (pixelclk),
    .reset_n         (reset_n),
    .i_r             (i_r),
    .i_g             (i_g),
    .i_b             (i_b),
    .i_transmittance (i_transmittance),
    .i_atmos         (i_atmos),
    .i_hsync         (i_hsync),
    .i_vsync         (i_vsync),
    .i_de            (i_de),
`ifdef DEHAZE_RECOVER_BYPASS_EN
    .i_bypass        (i_bypass),
`endif
    .o_r             (o_r),
    .o_g             (o_g),
    .o_b             (o_b),
    .o_hsync         (o_hsync),
    .o_vsync         (o_vsync),
    .o_de            (o_de)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pixelclk);
    #1;
  endtask

  // One pixel with de=1, then idle; output must appear exactly 5 cycles later.
  task automatic send_check(input string tag,
                            input logic [7:0] r, g, b, t, atmos,
                            input logic hs, vs,
                            input logic [7:0] er, eg, eb);
    i_r = r; i_g = g; i_b = b; i_transmittance = t; i_atmos = atmos;
    i_hsync = hs; i_vsync = vs; i_de = 1'b1;
    step();
    i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
    step(); step(); step();
    check({tag, "/de_early"}, o_de, 0);
    step();
    check({tag, "/de"}, o_de, 1);
    check({tag, "/hs"}, o_hsync, hs);
    check({tag, "/vs"}, o_vsync, vs);
    check({tag, "/r"}, o_r, er);
    check({tag, "/g"}, o_g, eg);
    check({tag, "/b"}, o_b, eb);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset with busy inputs: everything must read zero.
    reset_n = 1'b0;
    i_r = 8'd9; i_g = 8'd9; i_b = 8'd9; i_transmittance = 8'd255; i_atmos = 8'd7;
    i_hsync = 1'b1; i_vsync = 1'b1; i_de = 1'b1;
    step(); step(); step();
    check("reset/r", o_r, 0);
    check("reset/g", o_g, 0);
    check("reset/b", o_b, 0);
    check("reset/hs", o_hsync, 0);
    check("reset/vs", o_vsync, 0);
    check("reset/de", o_de, 0);
    reset_n = 1'b1;
    i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;

    // No vsync yet: A = 255 from reset, i_atmos ignored. d=-155, rcp=326 -> 58.
    send_check("a_reset", 100, 100, 100, 200, 0, 1, 0, 58, 58, 58);
    // t=255 -> rcp=256, J = I; vsync rise latches A=200 on this pixel.
    send_check("identity", 100, 50, 250, 255, 200, 1, 1, 100, 50, 250);
    // A=200, t=128, rcp=510: 100 -> 1, 200 -> 200, 0 -> -198 -> 0.
    send_check("half", 100, 200, 0, 128, 200, 0, 0, 1, 200, 0);
    // A=100, t=30, rcp=2176: 255 -> 1418 -> 255.
    send_check("overflow", 255, 255, 255, 30, 100, 0, 1, 255, 255, 255);
    // A=200, t=60, rcp=1088: 0 -> -650 -> 0.
    send_check("underflow", 0, 200, 0, 60, 200, 0, 1, 0, 200, 0);
    // A=180, t below/at T_MIN both use rcp=2511: 150 -> 0, 185 -> 229, 180 -> 180.
    send_check("tmin10", 150, 185, 180, 10, 180, 0, 1, 0, 229, 180);
    send_check("tmin26", 150, 185, 180, 26, 180, 0, 0, 0, 229, 180);
    // A latching: I=200, t=128. A=180 -> 220, A=220 -> 180.
    send_check("a_latch180", 200, 200, 200, 128, 180, 0, 1, 220, 220, 220);
    send_check("a_hold", 200, 200, 200, 128, 220, 0, 0, 220, 220, 220);
    send_check("a_latch220", 200, 200, 200, 128, 220, 0, 1, 180, 180, 180);

`ifdef DEHAZE_RECOVER_BYPASS_EN
    i_bypass = 1'b1;
    send_check("bypass", 10, 20, 30, 30, 100, 0, 0, 10, 20, 30);
    i_bypass = 1'b0;
`endif

    // Mid-frame reset during an active stream.
    i_r = 8'd77; i_g = 8'd77; i_b = 8'd77; i_transmittance = 8'd255;
    i_hsync = 1'b1; i_vsync = 1'b0; i_de = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("stream/de", o_de, 1);
    check("stream/r", o_r, 77);
    reset_n = 1'b0;
    step();
    check("midreset/de", o_de, 0);
    check("midreset/r", o_r, 0);
    check("midreset/hs", o_hsync, 0);
    step();
    reset_n = 1'b1;
    i_hsync = 1'b0; i_de = 1'b0;
    // A back at 255 (previous frame used 220); first output 5 cycles later.
    send_check("post_reset", 100, 100, 100, 200, 0, 1, 0, 58, 58, 58);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
